// File: rtl/rf_param.sv
// rf_param: parameterised MIPS register file with two registered read ports,
// one write port with same-cycle bypass, optional hardwired-zero register 0,
// and a start/finish bulk-clear sequencer that zeroes one entry per cycle.
module rf_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] read_addr_s,
  input  logic [ADDR_WIDTH-1:0] read_addr_t,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic                  write_enabled,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  busy,
  output logic                  finish,
  output logic [DATA_WIDTH-1:0] outA,
  output logic [DATA_WIDTH-1:0] outB
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    Idle,
    Clear,
    Done
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clrIdx_q, clrIdx_d;
  logic                  busy_q, busy_d;
  logic                  finish_q, finish_d;
  logic [DATA_WIDTH-1:0] outA_q, outA_d;
  logic [DATA_WIDTH-1:0] outB_q, outB_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  clearing;
  logic                  writeAccept;

  assign clearing    = (state_q == Clear);
  assign writeAccept = write_enabled && !clearing &&
                       !((ZERO_REG != 0) && (write_addr == '0));

  assign busy   = busy_q;
  assign finish = finish_q;
  assign outA   = outA_q;
  assign outB   = outB_q;

  // Sequencer next state: Idle waits for start, Clear walks every index, Done lasts one cycle.
  always_comb begin
    state_d  = state_q;
    clrIdx_d = clrIdx_q;
    case (state_q)
      Idle: begin
        if (start) begin
          state_d  = Clear;
          clrIdx_d = '0;
        end
      end
      Clear: begin
        if (clrIdx_q == LastIdx) begin
          state_d = Done;
        end else begin
          clrIdx_d = clrIdx_q + 1'b1;
        end
      end
      Done: begin
        state_d = Idle;
      end
      default: begin
        state_d = Idle;
      end
    endcase
    busy_d   = (state_d == Clear);
    finish_d = (state_d == Done);
  end

  // Read data selection, lowest priority first so later assignments win: array, bypass, zero reg, clear.
  always_comb begin
    outA_d = mem_q[read_addr_s];
    outB_d = mem_q[read_addr_t];
    if (write_enabled && (write_addr == read_addr_s)) outA_d = write_data;
    if (write_enabled && (write_addr == read_addr_t)) outB_d = write_data;
    if ((ZERO_REG != 0) && (read_addr_s == '0)) outA_d = '0;
    if ((ZERO_REG != 0) && (read_addr_t == '0)) outB_d = '0;
    if (clearing) begin
      outA_d = '0;
      outB_d = '0;
    end
  end

  // Control and read-port registers; reset aborts any clear in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= Idle;
      clrIdx_q <= '0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      outA_q   <= '0;
      outB_q   <= '0;
    end else begin
      state_q  <= state_d;
      clrIdx_q <= clrIdx_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
      outA_q   <= outA_d;
      outB_q   <= outB_d;
    end
  end

  // Storage array is deliberately not reset; the clear sequencer owns it while busy, otherwise the write port.
  always_ff @(posedge clock) begin
    if (clearing) begin
      mem_q[clrIdx_q] <= '0;
    end else if (writeAccept) begin
      mem_q[write_addr] <= write_data;
    end
  end

endmodule

// File: tb/tb_rf_param.sv
// tb_rf_param: drives two rf_param instances (32x32 with zero reg, 8x16 without)
// from one stimulus stream and scoreboards both against a behavioural model.
module tb_rf_param;

  typedef struct {
    int          dut;
    logic [31:0] a;
    logic [31:0] b;
    bit          careA;
    bit          careB;
    bit          busy;
    bit          fin;
  } exp_t;

  logic        clock;
  logic        resetN;
  logic        startIn;
  logic [4:0]  rdS, rdT, wrAddr;
  logic        wrEn;
  logic [31:0] wrData;

  logic        busy0, fin0, busy1, fin1;
  logic [31:0] outA0, outB0;
  logic [15:0] outA1, outB1;

  exp_t        sbq[$];
  logic [31:0] mdlMem   [2][32];
  bit          mdlKnown [2][32];
  int          clrPos   [2];
  bit          doneF    [2];
  int          depthOf  [2] = '{32, 8};
  bit          zr       [2] = '{1'b1, 1'b0};
  logic [31:0] dmask    [2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};

  int assertCount = 0;
  int failCount   = 0;

  rf_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut0 (
    .clock(clock), .reset_n(resetN), .start(startIn),
    .read_addr_s(rdS), .read_addr_t(rdT), .write_addr(wrAddr),
    .write_enabled(wrEn), .write_data(wrData),
    .busy(busy0), .finish(fin0), .outA(outA0), .outB(outB0)
  );

  rf_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(0)) dut1 (
    .clock(clock), .reset_n(resetN), .start(startIn),
    .read_addr_s(rdS[2:0]), .read_addr_t(rdT[2:0]), .write_addr(wrAddr[2:0]),
    .write_enabled(wrEn), .write_data(wrData[15:0]),
    .busy(busy1), .finish(fin1), .outA(outA1), .outB(outB1)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    assertCount++;
    if (act !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void readModel(input int d, input int a, input bit busyNow, input int wa,
                                    input bit we, input logic [31:0] wd,
                                    output logic [31:0] v, output bit care);
    care = 1'b1;
    if (busyNow) v = 32'h0;
    else if (zr[d] && a == 0) v = 32'h0;
    else if (we && wa == a) v = wd;
    else begin
      v    = mdlMem[d][a];
      care = mdlKnown[d][a];
    end
  endfunction

  // One clock edge of the reference behaviour for instance d; pushes the expected post-edge outputs.
  function automatic void modelStep(input int d, input bit st, input logic [4:0] ra, input logic [4:0] rb,
                                    input logic [4:0] waIn, input bit we, input logic [31:0] wdIn);
    int          m;
    int          ai, bi, wa;
    logic [31:0] wd;
    bit          busyNow;
    exp_t        e;
    m  = depthOf[d] - 1;
    ai = int'(ra) & m;
    bi = int'(rb) & m;
    wa = int'(waIn) & m;
    wd = wdIn & dmask[d];
    busyNow = (clrPos[d] >= 0);
    e.dut = d;
    readModel(d, ai, busyNow, wa, we, wd, e.a, e.careA);
    readModel(d, bi, busyNow, wa, we, wd, e.b, e.careB);
    if (busyNow) begin
      mdlMem[d][clrPos[d]]   = 32'h0;
      mdlKnown[d][clrPos[d]] = 1'b1;
    end else if (we && !(zr[d] && wa == 0)) begin
      mdlMem[d][wa]   = wd;
      mdlKnown[d][wa] = 1'b1;
    end
    if (doneF[d]) begin
      doneF[d] = 1'b0;
    end else if (busyNow) begin
      if (clrPos[d] == m) begin
        clrPos[d] = -1;
        doneF[d]  = 1'b1;
      end else begin
        clrPos[d]++;
      end
    end else if (st) begin
      clrPos[d] = 0;
    end
    e.busy = (clrPos[d] >= 0);
    e.fin  = doneF[d];
    sbq.push_back(e);
  endfunction

  function automatic void modelZeros(input int d);
    exp_t e;
    e.dut = d; e.a = 32'h0; e.b = 32'h0; e.careA = 1'b1; e.careB = 1'b1;
    e.busy = 1'b0; e.fin = 1'b0;
    sbq.push_back(e);
  endfunction

  task automatic applyStimulus(input bit st, input logic [4:0] ra, input logic [4:0] rb,
                               input logic [4:0] wa, input bit we, input logic [31:0] wd);
    @(negedge clock);
    resetN  = 1'b1;
    startIn = st;
    rdS     = ra;
    rdT     = rb;
    wrAddr  = wa;
    wrEn    = we;
    wrData  = wd;
    modelStep(0, st, ra, rb, wa, we, wd);
    modelStep(1, st, ra, rb, wa, we, wd);
  endtask

  task automatic doReset(input int nCycles);
    @(negedge clock);
    startIn = 1'b0;
    wrEn    = 1'b0;
    for (int d = 0; d < 2; d++) begin
      clrPos[d] = -1;
      doneF[d]  = 1'b0;
      modelZeros(d);
    end
    resetN = 1'b0;
    for (int i = 0; i < nCycles; i++) begin
      if (i > 0) @(negedge clock);
      modelZeros(0);
      modelZeros(1);
    end
  endtask

  task automatic readAll();
    for (int i = 0; i < 32; i++) applyStimulus(1'b0, 5'(i), 5'(31 - i), 5'd0, 1'b0, 32'h0);
  endtask

  task automatic fillAll();
    for (int i = 1; i < 32; i++) applyStimulus(1'b0, 5'(i), 5'(i), 5'(i), 1'b1, $urandom | 32'h0001_0001);
  endtask

  task automatic idleRandomReads(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'($urandom), 5'($urandom), 5'd0, 1'b0, 32'h0);
  endtask

  // Monitor: on every clock edge or asynchronous reset, pop one expectation per instance and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock or negedge resetN);
      #1;
      for (int k = 0; k < 2 && sbq.size() > 0; k++) begin
        e = sbq.pop_front();
        if (e.dut == 0) begin
          if (e.careA) checkOutput("dut0 outA", outA0, e.a);
          if (e.careB) checkOutput("dut0 outB", outB0, e.b);
          checkOutput("dut0 busy", {31'h0, busy0}, {31'h0, e.busy});
          checkOutput("dut0 finish", {31'h0, fin0}, {31'h0, e.fin});
        end else begin
          if (e.careA) checkOutput("dut1 outA", {16'h0, outA1}, e.a);
          if (e.careB) checkOutput("dut1 outB", {16'h0, outB1}, e.b);
          checkOutput("dut1 busy", {31'h0, busy1}, {31'h0, e.busy});
          checkOutput("dut1 finish", {31'h0, fin1}, {31'h0, e.fin});
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by a randomised soak.
  initial begin
    for (int d = 0; d < 2; d++) begin
      clrPos[d] = -1;
      doneF[d]  = 1'b0;
      for (int a = 0; a < 32; a++) begin
        mdlMem[d][a]   = 32'h0;
        mdlKnown[d][a] = 1'b0;
      end
    end
    resetN = 1'b1; startIn = 1'b0; rdS = '0; rdT = '0; wrAddr = '0; wrEn = 1'b0; wrData = '0;

    doReset(2);
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    idleRandomReads(36);
    readAll();

    applyStimulus(1'b0, 5'd1, 5'd2, 5'd5, 1'b1, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 5'd5, 5'd6, 5'd0, 1'b0, 32'h0);
    applyStimulus(1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 32'h1234_5678);
    applyStimulus(1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);

    fillAll();
    applyStimulus(1'b1, 5'd3, 5'd31, 5'd0, 1'b0, 32'h0);
    for (int c = 1; c <= 36; c++) begin
      if (c == 2)       applyStimulus(1'b0, 5'd3, 5'd31, 5'd3, 1'b1, 32'hAAAA_5555);
      else if (c == 30) applyStimulus(1'b0, 5'd3, 5'd31, 5'd31, 1'b1, 32'h5555_AAAA);
      else if (c == 10) applyStimulus(1'b1, 5'($urandom), 5'($urandom), 5'd0, 1'b0, 32'h0);
      else              applyStimulus(1'b0, 5'($urandom), 5'($urandom), 5'd0, 1'b0, 32'h0);
    end
    idleRandomReads(12);
    readAll();

    fillAll();
    applyStimulus(1'b1, 5'd20, 5'd1, 5'd0, 1'b0, 32'h0);
    idleRandomReads(10);
    doReset(2);
    idleRandomReads(40);
    readAll();

    for (int i = 0; i < 80; i++) applyStimulus(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, $urandom);
    idleRandomReads(40);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 149) == 0) doReset($urandom_range(1, 3));
      else applyStimulus($urandom_range(0, 39) == 0, 5'($urandom), 5'($urandom), 5'($urandom),
                         $urandom_range(0, 1) == 1, $urandom);
    end
    idleRandomReads(40);
    readAll();

    @(negedge clock);
    @(negedge clock);
    checkOutput("scoreboard drain", sbq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
